// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// forwarding-select encodings and the load result-source code.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // The younger producer (MEM) wins over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       we_mem,
    input logic [4:0] wa_mem,
    input logic       we_wb,
    input logic [4:0] wa_wb
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (we_mem && (wa_mem != 5'd0) && (wa_mem == src)) begin
      sel = FWD_MEM;
    end else if (we_wb && (wa_wb != 5'd0) && (wa_wb == src)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_perf.sv
// Saturating stall/flush cycle counters for the hazard controller; only
// instantiated when HAZARD_PERF_EN is defined.
module hazard_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // NOTE: sequential state is assigned with <= only, so every register in
  // this block samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (i_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, branch flush, data
// memory wait/timeout FSM and operand forwarding. Define HAZARD_PERF_EN to
// build the stall/flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       readAddress1_ID,
  input  logic [4:0]       readAddress2_ID,
  input  logic [4:0]       readAddress1_EX,
  input  logic [4:0]       readAddress2_EX,
  input  logic [4:0]       writeAddress_EX,
  input  logic [1:0]       resultSrc_EX,
  input  logic             regWrite_MEM,
  input  logic [4:0]       writeAddress_MEM,
  input  logic             regWrite_WB,
  input  logic [4:0]       writeAddress_WB,
  input  logic             PCSrc_EX,
  input  logic             memReq_MEM,
  input  logic             memReady_MEM,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             flush_ID,
  output logic             flush_EX,
  output logic [1:0]       forwardA_EX,
  output logic [1:0]       forwardB_EX,
  output logic             memTimeout,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_ldstall;
  logic              w_ldstall_nxt;

  logic              w_load_use;
  logic              w_mem_block;
  logic              w_stall_if;
  logic              w_stall_id;
  logic              w_stall_ex;
  logic              w_stall_mem;
  logic              w_flush_id;
  logic              w_flush_ex;
  logic              w_timeout;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  // r_ldstall masks the cycle right after a bubble so one load gives one bubble.
  assign w_load_use = (resultSrc_EX == RESULT_LOAD) &&
                      (writeAddress_EX != 5'd0) &&
                      ((writeAddress_EX == readAddress1_ID) ||
                       (writeAddress_EX == readAddress2_ID)) &&
                      !r_ldstall;

  assign w_mem_block = memReq_MEM && !memReady_MEM;

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_ldstall_nxt  = 1'b0;
    w_stall_if     = 1'b0;
    w_stall_id     = 1'b0;
    w_stall_ex     = 1'b0;
    w_stall_mem    = 1'b0;
    w_flush_id     = 1'b0;
    w_flush_ex     = 1'b0;
    w_timeout      = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        // A blocked memory access outranks a taken branch; the flush is
        // taken once the wait ends and PCSrc_EX is looked at again.
        if (w_mem_block) begin
          w_state_nxt    = ST_MEMWAIT;
          w_wait_cnt_nxt = '0;
          w_stall_if     = 1'b1;
          w_stall_id     = 1'b1;
          w_stall_ex     = 1'b1;
          w_stall_mem    = 1'b1;
        end else if (PCSrc_EX) begin
          w_flush_id = 1'b1;
          w_flush_ex = 1'b1;
        end else if (w_load_use) begin
          w_stall_if    = 1'b1;
          w_stall_id    = 1'b1;
          w_flush_ex    = 1'b1;
          w_ldstall_nxt = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_stall_ex  = 1'b1;
        w_stall_mem = 1'b1;
        if (memReady_MEM) begin
          w_state_nxt = ST_RUN;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt = ST_TIMEOUT;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_TIMEOUT: begin
        w_stall_if  = 1'b1;
        w_stall_id  = 1'b1;
        w_stall_ex  = 1'b1;
        w_stall_mem = 1'b1;
        w_timeout   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    // Reset is synchronous, so the outputs are forced here for the whole
    // reset window rather than waiting for the first edge.
    if (rst) begin
      w_stall_if  = 1'b0;
      w_stall_id  = 1'b0;
      w_stall_ex  = 1'b0;
      w_stall_mem = 1'b0;
      w_flush_id  = 1'b1;
      w_flush_ex  = 1'b1;
      w_timeout   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_ldstall  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_ldstall  <= w_ldstall_nxt;
    end
  end

  always_comb begin
    w_fwd_a = fwd_sel(readAddress1_EX, regWrite_MEM, writeAddress_MEM,
                      regWrite_WB, writeAddress_WB);
    w_fwd_b = fwd_sel(readAddress2_EX, regWrite_MEM, writeAddress_MEM,
                      regWrite_WB, writeAddress_WB);
    if (rst) begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
    end
  end

  assign stall_IF    = w_stall_if;
  assign stall_ID    = w_stall_id;
  assign stall_EX    = w_stall_ex;
  assign stall_MEM   = w_stall_mem;
  assign flush_ID    = w_flush_id;
  assign flush_EX    = w_flush_ex;
  assign forwardA_EX = w_fwd_a;
  assign forwardB_EX = w_fwd_b;
  assign memTimeout  = w_timeout;

`ifdef HAZARD_PERF_EN
  logic w_any_stall;
  logic w_any_flush;

  assign w_any_stall = w_stall_if | w_stall_id | w_stall_ex | w_stall_mem;
  assign w_any_flush = w_flush_id | w_flush_ex;

  hazard_perf #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (w_any_stall),
    .i_flush    (w_any_flush),
    .o_stall_cnt(stallCnt),
    .o_flush_cnt(flushCnt)
  );
`else
  assign stallCnt = '0;
  assign flushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MEM_TIMEOUT=4); counter
// expectations follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  logic             clk;
  logic             rst;
  logic [4:0]       readAddress1_ID, readAddress2_ID;
  logic [4:0]       readAddress1_EX, readAddress2_EX;
  logic [4:0]       writeAddress_EX;
  logic [1:0]       resultSrc_EX;
  logic             regWrite_MEM;
  logic [4:0]       writeAddress_MEM;
  logic             regWrite_WB;
  logic [4:0]       writeAddress_WB;
  logic             PCSrc_EX, memReq_MEM, memReady_MEM;
  logic             stall_IF, stall_ID, stall_EX, stall_MEM;
  logic             flush_ID, flush_EX;
  logic [1:0]       forwardA_EX, forwardB_EX;
  logic             memTimeout;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] EXP_STALLS = 32'd2;
  localparam logic [31:0] EXP_FLUSHES = 32'd3;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .readAddress1_ID (readAddress1_ID),
    .readAddress2_ID (readAddress2_ID),
    .readAddress1_EX (readAddress1_EX),
    .readAddress2_EX (readAddress2_EX),
    .writeAddress_EX (writeAddress_EX),
    .resultSrc_EX    (resultSrc_EX),
    .regWrite_MEM    (regWrite_MEM),
    .writeAddress_MEM(writeAddress_MEM),
    .regWrite_WB     (regWrite_WB),
    .writeAddress_WB (writeAddress_WB),
    .PCSrc_EX        (PCSrc_EX),
    .memReq_MEM      (memReq_MEM),
    .memReady_MEM    (memReady_MEM),
    .stall_IF        (stall_IF),
    .stall_ID        (stall_ID),
    .stall_EX        (stall_EX),
    .stall_MEM       (stall_MEM),
    .flush_ID        (flush_ID),
    .flush_EX        (flush_EX),
    .forwardA_EX     (forwardA_EX),
    .forwardB_EX     (forwardB_EX),
    .memTimeout      (memTimeout),
    .stallCnt        (stallCnt),
    .flushCnt        (flushCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    readAddress1_ID  = '0;
    readAddress2_ID  = '0;
    readAddress1_EX  = '0;
    readAddress2_EX  = '0;
    writeAddress_EX  = '0;
    resultSrc_EX     = '0;
    regWrite_MEM     = 1'b0;
    writeAddress_MEM = '0;
    regWrite_WB      = 1'b0;
    writeAddress_WB  = '0;
    PCSrc_EX         = 1'b0;
    memReq_MEM       = 1'b0;
    memReady_MEM     = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset window: outputs forced even with a forwarding match present.
    rst = 1'b1;
    clear_inputs();
    regWrite_MEM = 1'b1; writeAddress_MEM = 5'd7; readAddress1_EX = 5'd7;
    #2;
    check("rst_stall_IF", stall_IF, 0);
    check("rst_stall_MEM", stall_MEM, 0);
    check("rst_flush_ID", flush_ID, 1);
    check("rst_flush_EX", flush_EX, 1);
    check("rst_fwdA", forwardA_EX, 2'b00);
    check("rst_timeout", memTimeout, 0);
    tick(); tick();
    check("rst_stallCnt", stallCnt, 0);
    check("rst_flushCnt", flushCnt, 0);
    rst = 1'b0;
    clear_inputs();
    #1;
    check("idle_flush_ID", flush_ID, 0);
    check("idle_stall_IF", stall_IF, 0);

    // Load-use on x5 through rs1: one bubble, then suppressed.
    resultSrc_EX = 2'b01; writeAddress_EX = 5'd5; readAddress1_ID = 5'd5;
    #1;
    check("lu_stall_IF", stall_IF, 1);
    check("lu_stall_ID", stall_ID, 1);
    check("lu_flush_EX", flush_EX, 1);
    check("lu_flush_ID", flush_ID, 0);
    check("lu_stall_EX", stall_EX, 0);
    tick();
    check("lu2_stall_IF", stall_IF, 0);
    check("lu2_stall_ID", stall_ID, 0);
    check("lu2_flush_EX", flush_EX, 0);
    clear_inputs();
    tick();

    // Non-load result source and x0 destination never stall.
    resultSrc_EX = 2'b00; writeAddress_EX = 5'd5; readAddress1_ID = 5'd5;
    #1;
    check("nolu_alu", stall_IF, 0);
    resultSrc_EX = 2'b01; writeAddress_EX = 5'd0; readAddress1_ID = 5'd0;
    #1;
    check("nolu_x0", stall_IF, 0);

    // Second load-use, through rs2.
    writeAddress_EX = 5'd9; readAddress2_ID = 5'd9;
    #1;
    check("lu_rs2_stall_ID", stall_ID, 1);
    check("lu_rs2_flush_EX", flush_EX, 1);
    tick();
    clear_inputs();
    #1;

    // Branch together with a load-use: branch wins.
    PCSrc_EX = 1'b1; resultSrc_EX = 2'b01; writeAddress_EX = 5'd5; readAddress1_ID = 5'd5;
    #1;
    check("br_flush_ID", flush_ID, 1);
    check("br_flush_EX", flush_EX, 1);
    check("br_stall_IF", stall_IF, 0);
    check("br_stall_ID", stall_ID, 0);
    tick();
    clear_inputs();
    #1;
    check("perf_stallCnt", stallCnt, EXP_STALLS);
    check("perf_flushCnt", flushCnt, EXP_FLUSHES);

    // Memory wait: ready low 3 cycles, branch deferred until the wait ends.
    memReq_MEM = 1'b1; memReady_MEM = 1'b0; PCSrc_EX = 1'b1;
    #1;
    check("mw0_stall_IF", stall_IF, 1);
    check("mw0_stall_MEM", stall_MEM, 1);
    check("mw0_flush_ID", flush_ID, 0);
    tick();
    check("mw1_stall_EX", stall_EX, 1);
    check("mw1_flush_EX", flush_EX, 0);
    tick();
    regWrite_WB = 1'b1; writeAddress_WB = 5'd3; readAddress2_EX = 5'd3;
    #1;
    check("mw2_fwdB_wb", forwardB_EX, 2'b01);
    check("mw2_stall_ID", stall_ID, 1);
    tick();
    memReady_MEM = 1'b1;
    #1;
    check("mw3_stall_MEM", stall_MEM, 1);
    tick();
    memReq_MEM = 1'b0; memReady_MEM = 1'b0;
    #1;
    check("mw4_stall_IF", stall_IF, 0);
    check("mw4_stall_MEM", stall_MEM, 0);
    check("mw4_flush_ID", flush_ID, 1);
    clear_inputs();
    tick();

    // Forwarding priority and x0 exclusion.
    regWrite_MEM = 1'b1; writeAddress_MEM = 5'd7;
    regWrite_WB  = 1'b1; writeAddress_WB  = 5'd7;
    readAddress1_EX = 5'd7; readAddress2_EX = 5'd7;
    #1;
    check("fwdA_mem", forwardA_EX, 2'b10);
    check("fwdB_mem", forwardB_EX, 2'b10);
    writeAddress_MEM = 5'd0;
    #1;
    check("fwdA_wb", forwardA_EX, 2'b01);
    regWrite_WB = 1'b0;
    #1;
    check("fwdA_rf", forwardA_EX, 2'b00);
    writeAddress_MEM = 5'd4; readAddress2_EX = 5'd4;
    #1;
    check("fwdB_mem_rs2", forwardB_EX, 2'b10);
    check("fwdA_rf2", forwardA_EX, 2'b00);
    clear_inputs();
    tick();

    // Timeout after 4 MEMWAIT cycles, sticky until reset.
    memReq_MEM = 1'b1; memReady_MEM = 1'b0;
    #1;
    check("to0_stall_MEM", stall_MEM, 1);
    check("to0_timeout", memTimeout, 0);
    repeat (4) tick();
    check("to4_timeout", memTimeout, 0);
    tick();
    check("to5_timeout", memTimeout, 1);
    check("to5_stall_IF", stall_IF, 1);
    check("to5_flush_ID", flush_ID, 0);
    memReady_MEM = 1'b1;
    #1;
    check("to_ready_timeout", memTimeout, 1);
    tick();
    check("to_held_timeout", memTimeout, 1);
    check("to_held_stall_EX", stall_EX, 1);
    rst = 1'b1;
    #1;
    check("to_rst_timeout", memTimeout, 0);
    check("to_rst_stall_IF", stall_IF, 0);
    check("to_rst_flush_ID", flush_ID, 1);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("to_after_timeout", memTimeout, 0);
    check("to_after_stall_MEM", stall_MEM, 0);
    check("to_after_flush_EX", flush_EX, 0);

    // Reset during MEMWAIT leaves no residual stall.
    memReq_MEM = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("mwrst_stall_IF", stall_IF, 0);
    check("mwrst_stall_MEM", stall_MEM, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
